// File: rtl/ca_code_pkg.sv
// rtl/ca_code_pkg.sv - C/A code constants, G2 tap table, channel config type and chip helper
package ca_code_pkg;

  localparam int CODE_LEN = 1023;
  localparam logic [10:1] LFSR_INIT = 10'h3FF;
  // Feedback masks over stages [10:1]: G1 = 1+x3+x10, G2 = 1+x2+x3+x6+x8+x9+x10
  localparam logic [10:1] G1_POLY = 10'b1000000100;
  localparam logic [10:1] G2_POLY = 10'b1110100110;

  // {tapA, tapB} G2 stage pairs for PRN 1..32, stored at index prn-1
  localparam logic [7:0] G2_TAPS [0:31] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  typedef struct packed {
    logic [5:0] prn;
    logic       en;
    logic       restart;
  } ch_cfg_t;

  function automatic logic code_chip(input logic [10:1] g1, input logic [10:1] g2,
                                     input logic [5:0] prn);
    logic [7:0] taps;
    code_chip = 1'b0;
    taps      = 8'h00;
    if (prn >= 6'd1 && prn <= 6'd32) begin
      taps      = G2_TAPS[5'(prn - 6'd1)];
      code_chip = g1[10] ^ g2[taps[7:4]] ^ g2[taps[3:0]];
    end
  endfunction

endpackage

// File: rtl/ca_code_gen.sv
// rtl/ca_code_gen.sv - one channel's G1/G2 Gold code generator with chip counter
// Optional wrap output present only when CA_CODE_NCO_EPOCH_EN is defined.
module ca_code_gen
  import ca_code_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       restart,
  input  logic [5:0] prn,
`ifdef CA_CODE_NCO_EPOCH_EN
  output logic       wrap,
`endif
  output logic       chip
);

  logic [10:1] g1, g2, g1_n, g2_n;
  logic [9:0]  chip_cnt, cnt_n;
  logic        at_end;

  assign at_end = (chip_cnt == 10'(CODE_LEN - 1));

  always_comb begin
    g1_n  = g1;
    g2_n  = g2;
    cnt_n = chip_cnt;
    if (restart || (advance && at_end)) begin
      g1_n  = LFSR_INIT;
      g2_n  = LFSR_INIT;
      cnt_n = '0;
    end else if (advance) begin
      g1_n  = {g1[9:1], ^(g1 & G1_POLY)};
      g2_n  = {g2[9:1], ^(g2 & G2_POLY)};
      cnt_n = chip_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g1       <= LFSR_INIT;
      g2       <= LFSR_INIT;
      chip_cnt <= '0;
    end else begin
      g1       <= g1_n;
      g2       <= g2_n;
      chip_cnt <= cnt_n;
    end
  end

  // Chip of the state this update leaves behind, so the top can register it in the same edge
  assign chip = code_chip(g1_n, g2_n, prn);

`ifdef CA_CODE_NCO_EPOCH_EN
  assign wrap = advance & ~restart & at_end;
`endif

endmodule

// File: rtl/ca_code_nco_mc.sv
// rtl/ca_code_nco_mc.sv - multi-channel NCO-driven C/A code generator with shadowed config
// Defining CA_CODE_NCO_EPOCH_EN adds the per-channel epoch output.
module ca_code_nco_mc
  import ca_code_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dv_in,
  input  logic               cfg_wr,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [5:0]         cfg_prn,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic               cfg_en,
  input  logic               cfg_restart,
  output logic               dv_out,
`ifdef CA_CODE_NCO_EPOCH_EN
  output logic [NUM_CH-1:0]  epoch,
`endif
  output logic [NUM_CH-1:0]  q
);

  logic [NUM_CH-1:0] q_next;
`ifdef CA_CODE_NCO_EPOCH_EN
  logic [NUM_CH-1:0] wrap_v;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PHASE_W-1:0] acc, freq_r, shd_freq;
    logic [PHASE_W:0]   sum;
    logic [5:0]         prn_r, prn_next;
    logic               en_r, en_next, pending, commit, do_restart, advance, chip;
    ch_cfg_t            shd;

    assign sum        = {1'b0, acc} + {1'b0, freq_r};
    assign commit     = dv_in & pending;
    assign do_restart = commit & shd.restart;
    assign advance    = dv_in & en_r & sum[PHASE_W] & ~do_restart;
    assign prn_next   = commit ? shd.prn : prn_r;
    assign en_next    = commit ? shd.en : en_r;

    always_ff @(posedge clk) begin
      if (reset) begin
        acc      <= '0;
        freq_r   <= '0;
        prn_r    <= 6'd1;
        en_r     <= 1'b0;
        pending  <= 1'b0;
        shd      <= '0;
        shd_freq <= '0;
      end else begin
        if (do_restart) acc <= '0;
        else if (dv_in && en_r) acc <= sum[PHASE_W-1:0];
        if (commit) begin
          prn_r   <= shd.prn;
          freq_r  <= shd_freq;
          en_r    <= shd.en;
          pending <= 1'b0;
        end
        // A write landing on a commit cycle re-arms pending for the following dv_in
        if (cfg_wr && cfg_ch == CH_W'(i)) begin
          shd      <= '{prn: cfg_prn, en: cfg_en, restart: cfg_restart};
          shd_freq <= cfg_freq;
          pending  <= 1'b1;
        end
      end
    end

    ca_code_gen u_gen (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .restart (do_restart),
      .prn     (prn_next),
`ifdef CA_CODE_NCO_EPOCH_EN
      .wrap    (wrap_v[i]),
`endif
      .chip    (chip)
    );

    assign q_next[i] = en_next & chip;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dv_out <= 1'b0;
      q      <= '0;
`ifdef CA_CODE_NCO_EPOCH_EN
      epoch  <= '0;
`endif
    end else begin
      dv_out <= dv_in;
      if (dv_in) q <= q_next;
`ifdef CA_CODE_NCO_EPOCH_EN
      epoch  <= dv_in ? wrap_v : '0;
`endif
    end
  end

endmodule

// File: tb/tb_ca_code_nco_mc.sv
// tb/tb_ca_code_nco_mc.sv - scoreboard bench for ca_code_nco_mc (epoch checks with CA_CODE_NCO_EPOCH_EN)
module tb_ca_code_nco_mc;
  localparam int NCH = 3;
  localparam int PW  = 32;

  logic clk = 1'b0;
  logic reset, dv_in, cfg_wr, cfg_en, cfg_restart, dv_out;
  logic [1:0]    cfg_ch;
  logic [5:0]    cfg_prn;
  logic [PW-1:0] cfg_freq;
  logic [NCH-1:0] q;
`ifdef CA_CODE_NCO_EPOCH_EN
  logic [NCH-1:0] epoch;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ca_code_nco_mc #(.NUM_CH(NCH), .PHASE_W(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .dv_in       (dv_in),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_prn     (cfg_prn),
    .cfg_freq    (cfg_freq),
    .cfg_en      (cfg_en),
    .cfg_restart (cfg_restart),
    .dv_out      (dv_out),
`ifdef CA_CODE_NCO_EPOCH_EN
    .epoch       (epoch),
`endif
    .q           (q)
  );

  // Reference code sequences from the recurrences x(k)=x(k-3)^x(k-10) and the G2 equivalent
  bit g1s [0:2047];
  bit g2s [0:2047];
  int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  logic [PW-1:0] m_acc [NCH];
  logic [PW-1:0] m_freq [NCH];
  logic [PW-1:0] s_freq [NCH];
  int m_idx [NCH];
  int m_prn [NCH];
  int s_prn [NCH];
  bit m_en [NCH];
  bit m_pend [NCH];
  bit s_en [NCH];
  bit s_rs [NCH];
  logic [2*NCH-1:0] exp_q [$];
  logic [NCH-1:0] last_q;
  logic [9:0] seq0, seq1, ref1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit chipval(input int prn, input int n);
    if (prn < 1 || prn > 32) return 1'b0;
    return g1s[n] ^ g2s[n + 10 - tap_a[prn-1]] ^ g2s[n + 10 - tap_b[prn-1]];
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = '0; m_freq[c] = '0; m_idx[c] = 0; m_prn[c] = 1;
      m_en[c] = 1'b0; m_pend[c] = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic cyc(input bit d, input bit w, input int ch, input int prn,
                     input logic [PW-1:0] fr, input bit en, input bit rs);
    logic [NCH-1:0] eq, ee;
    logic [PW:0] sum;
    dv_in = d; cfg_wr = w; cfg_ch = 2'(ch); cfg_prn = 6'(prn);
    cfg_freq = fr; cfg_en = en; cfg_restart = rs;
    if (d && reset !== 1'b1) begin
      eq = '0; ee = '0;
      for (int c = 0; c < NCH; c++) begin
        if (m_pend[c] && s_rs[c]) begin
          m_acc[c] = '0; m_idx[c] = 0;
        end else if (m_en[c]) begin
          sum = {1'b0, m_acc[c]} + {1'b0, m_freq[c]};
          m_acc[c] = sum[PW-1:0];
          if (sum[PW]) begin
            m_idx[c] = m_idx[c] + 1;
            if (m_idx[c] == 1023) begin m_idx[c] = 0; ee[c] = 1'b1; end
          end
        end
        if (m_pend[c]) begin
          m_prn[c] = s_prn[c]; m_freq[c] = s_freq[c]; m_en[c] = s_en[c]; m_pend[c] = 1'b0;
        end
        eq[c] = m_en[c] & chipval(m_prn[c], m_idx[c]);
      end
      exp_q.push_back({ee, eq});
    end
    if (w && reset !== 1'b1 && ch < NCH) begin
      s_prn[ch] = prn; s_freq[ch] = fr; s_en[ch] = en; s_rs[ch] = rs; m_pend[ch] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int prn, input logic [PW-1:0] fr, input bit en, input bit rs);
    cyc(1'b0, 1'b1, ch, prn, fr, en, rs);
  endtask

  task automatic dvs(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      cyc(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
      repeat (gap - 1) cyc(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [2*NCH-1:0] e;
    if (reset === 1'b1) begin
      last_q = '0;
    end else if (dv_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("dv_out_spurious", 64'(dv_out), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("q", 64'(q), 64'(e[NCH-1:0]));
`ifdef CA_CODE_NCO_EPOCH_EN
        chk("epoch", 64'(epoch), 64'(e[2*NCH-1:NCH]));
`endif
      end
      last_q = q;
    end else begin
      chk("q_hold", 64'(q), 64'(last_q));
    end
  end

  initial begin
    for (int k = 0; k < 2048; k++) begin
      if (k < 10) begin
        g1s[k] = 1'b1; g2s[k] = 1'b1;
      end else begin
        g1s[k] = g1s[k-3] ^ g1s[k-10];
        g2s[k] = g2s[k-2] ^ g2s[k-3] ^ g2s[k-6] ^ g2s[k-8] ^ g2s[k-9] ^ g2s[k-10];
      end
    end
    ref1 = '0;
    for (int n = 0; n < 10; n++) ref1 = {ref1[8:0], chipval(3, n)};

    reset = 1'b1; dv_in = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_prn = '0;
    cfg_freq = '0; cfg_en = 1'b0; cfg_restart = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_q", 64'(q), 64'd0);
    chk("reset_dv_out", 64'(dv_out), 64'd0);
    reset = 1'b0;

    // PRN 1 on ch0 and PRN 3 on ch1, one sample per 64 clocks
    cfg(0, 1, '1, 1'b1, 1'b1);
    cfg(1, 3, '1, 1'b1, 1'b1);
    seq0 = '0; seq1 = '0;
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b1, 1'b0, 0, 0, '0, 1'b0, 1'b0);
      chk("dv_out_pulse", 64'(dv_out), 64'd1);
      if (k != 2) begin
        seq0 = {seq0[8:0], q[0]};
        seq1 = {seq1[8:0], q[1]};
      end
      repeat (63) cyc(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b0);
      chk("dv_out_one_cycle", 64'(dv_out), 64'd0);
    end
    chk("prn1_first10", 64'(seq0), 64'(10'o1440));
    chk("prn3_first10", 64'(seq1), 64'(ref1));

    // Frequency change with cfg_wr coincident with dv_in, continuous phase
    cfg(2, 7, 32'h27456789, 1'b1, 1'b1);
    dvs(6, 1);
    cyc(1'b1, 1'b1, 2, 7, 32'h12468ace, 1'b1, 1'b0);
    dvs(40, 1);

    // Disable then re-enable without restart
    cfg(2, 7, 32'h12468ace, 1'b0, 1'b0);
    cfg(0, 1, '1, 1'b0, 1'b0);
    dvs(30, 2);
    cfg(2, 7, 32'h12468ace, 1'b1, 1'b0);
    cfg(0, 1, '1, 1'b1, 1'b0);
    dvs(30, 1);

    // Last write wins, invalid PRNs, out-of-range channel write ignored
    cfg(1, 5, '1, 1'b1, 1'b0);
    cfg(1, 40, '1, 1'b1, 1'b0);
    cfg(3, 9, '1, 1'b1, 1'b1);
    dvs(6, 1);
    cfg(1, 0, '1, 1'b1, 1'b0);
    dvs(4, 1);
    cfg(1, 9, '1, 1'b1, 1'b0);
    dvs(8, 1);

    // Half-rate chipping through the full code period, back-to-back samples
    cfg(0, 1, 32'h80000000, 1'b1, 1'b1);
    dvs(2050, 1);

    // Reset mid-stream overrides a coincident dv_in and cfg_wr
    dvs(1, 4);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 0, 1, '1, 1'b1, 1'b1);
    reset = 1'b0;
    m_reset();
    chk("midreset_q", 64'(q), 64'd0);
    chk("midreset_dv_out", 64'(dv_out), 64'd0);
    dvs(5, 3);
    chk("post_reset_q_zero", 64'(q), 64'd0);
    cfg(0, 1, '1, 1'b1, 1'b1);
    cfg(2, 23, '1, 1'b1, 1'b1);
    dvs(12, 1);

    repeat (3) cyc(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
